pb_mcast_unroller: RTL and testbench
====================================

// Module: pb_mcast_unroller
// PURPOSE
// - Expands one masked multicast request (address + don't-care mask) into a sequence of unicast
//   beats, one per cluster tile covered by the mask, in ascending subset order.
// - Sits between a narrow/wide AXI AW front-end and a unicast-only NoC injection port; generalises
//   the fixed X/Y mask_sel rule to runtime offset/len per request and to arbitrary mesh sizes.
// - Drops destinations outside the mesh and uses one-beat lookahead, so out_last_o is exact.
// PARAMETERS
// - AddrWidth  48  request address width
// - UserWidth  8   opaque sideband copied to every beat
// - SelWidth   6   width of offset/len fields (matches mask_sel_t)
// - MeshDimX   4   valid X coordinates 0..MeshDimX-1
// - MeshDimY   4   valid Y coordinates 0..MeshDimY-1
// - CoordWidth 6   width of out_x_o / out_y_o
// PORTS
// - clk_i       in  1          clock
// - rst_i       in  1          synchronous, active-high reset
// - in_valid_i  in  1          request valid
// - in_ready_o  out 1          request accepted (high only in IDLE)
// - in_addr_i   in  AddrWidth  base address
// - in_mask_i   in  AddrWidth  1 = don't-care bit; bits outside the X/Y fields are ignored
// - in_sel_x_i  in  2*SelWidth {offset,len} of X field; in_sel_y_i same for Y field
// - in_user_i   in  UserWidth  sideband
// - out_valid_o out 1; out_ready_i in 1  unicast beat handshake
// - out_addr_o  out AddrWidth; out_x_o/out_y_o out CoordWidth; out_user_o out UserWidth
// - out_last_o  out 1          final beat of the current request
// - busy_o      out 1          not IDLE;  err_o out 1  1-cycle pulse: request hit zero in-range tiles
// BEHAVIOUR
// - Reset: all outputs 0 except in_ready_o=1; state IDLE; in-flight request discarded, no last beat.
// - Effective mask m = in_mask_i & (fieldX | fieldY); fields with len=0 are empty.
// - Subset walk: s0=0; s_next=((s|~m)+1)&m; walk exhausted when s_next==0. Dest addr=(addr&~m)|s.
// - Dest in range iff addr_x<MeshDimX && addr_y<MeshDimY (coords extracted from dest addr).
// - States: IDLE -> SCAN on in handshake (request registered at T). SCAN: one candidate per cycle;
//   out-of-range skipped silently. First in-range candidate loads hold reg -> HOLD_SCAN.
// - HOLD_SCAN: keep scanning for the next in-range candidate; out_valid_o=0 until found or
//   exhausted; then present held beat, out_last_o=exhausted -> EMIT.
// - EMIT: on out handshake, if last -> IDLE (in_ready_o=1 next cycle); else held<=next, continue
//   scanning. valid/data must not change while out_valid_o && !out_ready_i (AXI-style).
// - SCAN exhausted with no in-range candidate -> err_o pulse, IDLE, no beats emitted.
// - m==0: single beat, last=1, earliest out_valid_o at T+2 if in range.
// - Steady state: 1 beat/cycle with out_ready_i tied high and no skips.
// - len+offset beyond AddrWidth: out-of-field bits treated as 0 (no X/assertion).
// CONFIGURATION
// - PB_MCAST_UNROLL_STATS_EN defined: adds stat_beats_o, stat_skipped_o, stat_err_o (32b each, out),
//   saturating counters of emitted beats, skipped out-of-range candidates, err pulses; cleared by
//   rst_i only. Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
// - pb_mcast_pkg: mask_sel_t {offset,len}, mcast_req_t, mcast_beat_t, state enum, field-mask function.
// - Sub-module pb_mcast_subset_iter: registered subset walker (load, advance, s, exhausted).
// - Top: FSM, hold register, range check, optional stats.
// TESTING
// - addr x=1,y=2, m=0 -> one beat x1,y2, last=1, no err.
// - X len=2 mask 0b11, Y fixed 0, MeshDimX=4 -> x=0,1,2,3 y=0, last on x3, 4 beats back-to-back.
// - MeshDimX=3, same request -> x=0,1,2; last on x2 (x3 skipped); stats skipped=1 when enabled.
// - Base x=5 (>MeshDimX) and m=0 -> no beats, err_o one cycle, in_ready_o back next cycle.
// - X/Y 2x2 mask, out_ready_i random 50% -> 4 beats, data stable under backpressure, ordered (0,0),(1,0),(0,1),(1,1).
// - rst_i asserted mid-EMIT -> next cycle out_valid_o=0, busy_o=0, new request starts clean.

Source files
------------

// File: rtl/pb_mcast_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pb_mcast_pkg
// Description : Shared types and helpers for the multicast unroller: mask
//               selector, request/beat records, FSM state encoding and the
//               field mask / field extract functions.
// Revision    : 1.0 - initial release
// ============================================================================
package pb_mcast_pkg;

  localparam int unsigned ADDR_W  = 48;
  localparam int unsigned USER_W  = 8;
  localparam int unsigned SEL_W   = 6;
  localparam int unsigned COORD_W = 6;

  // Packed as {offset, len}; offset occupies the upper half.
  typedef struct packed {
    logic [SEL_W-1:0] offset;
    logic [SEL_W-1:0] len;
  } mask_sel_t;

  // Per-request context held for the whole walk (the mask lives in the walker).
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    mask_sel_t         sel_x;
    mask_sel_t         sel_y;
    logic [USER_W-1:0] user;
  } mcast_req_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } mcast_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SCAN      = 2'd1,
    ST_HOLD_SCAN = 2'd2,
    ST_EMIT      = 2'd3
  } state_e;

  // len low-order ones; a length reaching past the address saturates to all ones.
  function automatic logic [ADDR_W-1:0] low_ones(input logic [SEL_W-1:0] len);
    logic [ADDR_W-1:0] r;
    if (32'(len) >= ADDR_W) r = '1;
    else                    r = (ADDR_W'(1) << len) - ADDR_W'(1);
    return r;
  endfunction

  // Bits of the field inside the address; bits shifted past the top are lost,
  // so a field hanging off the end simply contributes zeros.
  function automatic logic [ADDR_W-1:0] field_mask(input mask_sel_t sel);
    return low_ones(sel.len) << sel.offset;
  endfunction

  // Right-justified field value; an empty field (len 0) reads as 0.
  function automatic logic [ADDR_W-1:0] field_extract(input logic [ADDR_W-1:0] addr,
                                                      input mask_sel_t         sel);
    return (addr >> sel.offset) & low_ones(sel.len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pb_mcast_subset_iter.sv
`default_nettype none
// ============================================================================
// Module      : pb_mcast_subset_iter
// Description : Registered walker over all subsets of a mask in ascending
//               order. One candidate is presented per cycle while active;
//               last_o flags the final subset of the walk.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_mcast_subset_iter #(
  parameter int unsigned Width = 48
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] mask_i,
  input  logic             advance_i,
  output logic             act_o,
  output logic [Width-1:0] s_o,
  output logic [Width-1:0] mask_o,
  output logic             last_o
);

  logic             act_q;
  logic [Width-1:0] s_q;
  logic [Width-1:0] m_q;
  logic [Width-1:0] s_next;

  // Forcing the non-mask bits to 1 lets the +1 carry ripple only through mask bits.
  assign s_next = ((s_q | ~m_q) + {{(Width-1){1'b0}}, 1'b1}) & m_q;
  assign last_o = (s_next == '0);
  assign act_o  = act_q;
  assign s_o    = s_q;
  assign mask_o = m_q;

  // Walker state: load restarts at the empty subset, advance steps or retires.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_q <= 1'b0;
      s_q   <= '0;
      m_q   <= '0;
    end else if (load_i) begin
      act_q <= 1'b1;
      s_q   <= '0;
      m_q   <= mask_i;
    end else if (advance_i && act_q) begin
      if (last_o) act_q <= 1'b0;
      else        s_q   <= s_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pb_mcast_unroller.sv
`default_nettype none
// ============================================================================
// Module      : pb_mcast_unroller
// Description : Expands a masked multicast request into ascending unicast
//               beats, dropping tiles outside the mesh. A one-candidate
//               lookahead register makes out_last_o exact.
//               Optional statistics counters: PB_MCAST_UNROLL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pb_mcast_unroller
  import pb_mcast_pkg::*;
#(
  parameter int unsigned AddrWidth  = ADDR_W,
  parameter int unsigned UserWidth  = USER_W,
  parameter int unsigned SelWidth   = SEL_W,
  parameter int unsigned MeshDimX   = 4,
  parameter int unsigned MeshDimY   = 4,
  parameter int unsigned CoordWidth = COORD_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [AddrWidth-1:0]  in_addr_i,
  input  logic [AddrWidth-1:0]  in_mask_i,
  input  logic [2*SelWidth-1:0] in_sel_x_i,
  input  logic [2*SelWidth-1:0] in_sel_y_i,
  input  logic [UserWidth-1:0]  in_user_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [AddrWidth-1:0]  out_addr_o,
  output logic [CoordWidth-1:0] out_x_o,
  output logic [CoordWidth-1:0] out_y_o,
  output logic [UserWidth-1:0]  out_user_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  err_o
`ifdef PB_MCAST_UNROLL_STATS_EN
  ,
  output logic [31:0]           stat_beats_o,
  output logic [31:0]           stat_skipped_o,
  output logic [31:0]           stat_err_o
`endif
);

  localparam logic [AddrWidth-1:0] MESH_X = AddrWidth'(MeshDimX);
  localparam logic [AddrWidth-1:0] MESH_Y = AddrWidth'(MeshDimY);

  state_e      state_q, state_d;
  mcast_req_t  req_q;
  mcast_beat_t hold_q;      // beat being presented
  mcast_beat_t nxt_q;       // next in-range beat (valid in EMIT when !last_q)
  mcast_beat_t cand_beat;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic                 it_load, it_adv, it_act, it_last;
  logic [AddrWidth-1:0] it_s, it_m;
  logic [AddrWidth-1:0] in_field_m;
  logic [AddrWidth-1:0] cand_addr, cand_x, cand_y;
  logic                 cand_in;
  logic                 out_fire;
  logic                 hold_ld_cand, hold_ld_nxt, nxt_ld, skip;

  assign in_field_m = in_mask_i & (field_mask(mask_sel_t'(in_sel_x_i)) |
                                   field_mask(mask_sel_t'(in_sel_y_i)));

  pb_mcast_subset_iter #(
    .Width (AddrWidth)
  ) u_iter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (it_load),
    .mask_i    (in_field_m),
    .advance_i (it_adv),
    .act_o     (it_act),
    .s_o       (it_s),
    .mask_o    (it_m),
    .last_o    (it_last)
  );

  // Current candidate destination, its coordinates and the mesh range test.
  always_comb begin
    cand_addr      = (req_q.addr & ~it_m) | it_s;
    cand_x         = field_extract(cand_addr, req_q.sel_x);
    cand_y         = field_extract(cand_addr, req_q.sel_y);
    cand_in        = it_act && (cand_x < MESH_X) && (cand_y < MESH_Y);
    cand_beat.addr = cand_addr;
    cand_beat.x    = cand_x[CoordWidth-1:0];
    cand_beat.y    = cand_y[CoordWidth-1:0];
  end

  assign out_fire = (state_q == ST_EMIT) && out_ready_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus walker / hold-register control.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    err_d        = 1'b0;
    it_load      = 1'b0;
    it_adv       = 1'b0;
    hold_ld_cand = 1'b0;
    hold_ld_nxt  = 1'b0;
    nxt_ld       = 1'b0;
    skip         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          it_load = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        it_adv = 1'b1;
        if (cand_in) begin
          hold_ld_cand = 1'b1;
          if (it_last) begin
            last_d  = 1'b1;
            state_d = ST_EMIT;
          end else begin
            state_d = ST_HOLD_SCAN;
          end
        end else begin
          skip = 1'b1;
          if (it_last) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD_SCAN: begin
        it_adv = 1'b1;
        if (cand_in) begin
          // A successor exists: park it in nxt_q, the held beat is not last.
          nxt_ld  = 1'b1;
          last_d  = 1'b0;
          state_d = ST_EMIT;
        end else begin
          skip = 1'b1;
          if (it_last) begin
            last_d  = 1'b1;
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (last_q) begin
          if (out_fire) state_d = ST_IDLE;
        end else if (out_fire) begin
          hold_ld_nxt = 1'b1;
          if (!it_act) begin
            last_d = 1'b1;
          end else if (cand_in) begin
            nxt_ld = 1'b1;
            it_adv = 1'b1;
          end else begin
            it_adv = 1'b1;
            skip   = 1'b1;
            if (it_last) last_d  = 1'b1;
            else         state_d = ST_HOLD_SCAN;
          end
        end else if (it_act && !cand_in) begin
          // Stalled downstream: still safe to discard out-of-range candidates.
          it_adv = 1'b1;
          skip   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from state and registered data only.
  always_comb begin
    in_ready_o  = (state_q == ST_IDLE);
    busy_o      = (state_q != ST_IDLE);
    out_valid_o = (state_q == ST_EMIT);
    out_last_o  = (state_q == ST_EMIT) && last_q;
    out_addr_o  = hold_q.addr;
    out_x_o     = hold_q.x;
    out_y_o     = hold_q.y;
    out_user_o  = req_q.user;
    err_o       = err_q;
  end

  // Request capture, presented beat, lookahead beat and flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q  <= '0;
      hold_q <= '0;
      nxt_q  <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (it_load) begin
        req_q.addr  <= in_addr_i;
        req_q.sel_x <= mask_sel_t'(in_sel_x_i);
        req_q.sel_y <= mask_sel_t'(in_sel_y_i);
        req_q.user  <= in_user_i;
      end
      if (hold_ld_cand)     hold_q <= cand_beat;
      else if (hold_ld_nxt) hold_q <= nxt_q;
      if (nxt_ld) nxt_q <= cand_beat;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

`ifdef PB_MCAST_UNROLL_STATS_EN
  logic [31:0] stat_beats_q, stat_skipped_q, stat_err_q;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_beats_q   <= '0;
      stat_skipped_q <= '0;
      stat_err_q     <= '0;
    end else begin
      if (out_fire && (stat_beats_q != '1))   stat_beats_q   <= stat_beats_q + 32'd1;
      if (skip && (stat_skipped_q != '1))     stat_skipped_q <= stat_skipped_q + 32'd1;
      if (err_d && (stat_err_q != '1))        stat_err_q     <= stat_err_q + 32'd1;
    end
  end

  assign stat_beats_o   = stat_beats_q;
  assign stat_skipped_o = stat_skipped_q;
  assign stat_err_o     = stat_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pb_mcast_unroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pb_mcast_unroller
// Description : Directed self-checking bench. Two instances share stimulus:
//               dut A on a 4x4 mesh and dut B with MeshDimX=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_mcast_unroller;

  typedef struct {
    logic [47:0] addr;
    logic [5:0]  x;
    logic [5:0]  y;
    logic        last;
    logic [7:0]  user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [47:0] in_addr, in_mask;
  logic [11:0] in_sel_x, in_sel_y;
  logic [7:0]  in_user;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_last, a_busy, a_err;
  logic [47:0] a_addr;
  logic [5:0]  a_x, a_y;
  logic [7:0]  a_user;
  logic        b_in_ready, b_out_valid, b_last, b_busy, b_err;
  logic [47:0] b_addr;
  logic [5:0]  b_x, b_y;
  logic [7:0]  b_user;
`ifdef PB_MCAST_UNROLL_STATS_EN
  logic [31:0] a_sb, a_ss, a_se, b_sb, b_ss, b_se;
`endif

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    a_err_cnt = 0;
  beat_t qa[$];
  beat_t qb[$];
  int    ca[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  pb_mcast_unroller #(.MeshDimX(4), .MeshDimY(4)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .in_addr_i(in_addr), .in_mask_i(in_mask), .in_sel_x_i(in_sel_x), .in_sel_y_i(in_sel_y),
    .in_user_i(in_user), .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .out_addr_o(a_addr), .out_x_o(a_x), .out_y_o(a_y), .out_user_o(a_user),
    .out_last_o(a_last), .busy_o(a_busy), .err_o(a_err)
`ifdef PB_MCAST_UNROLL_STATS_EN
    , .stat_beats_o(a_sb), .stat_skipped_o(a_ss), .stat_err_o(a_se)
`endif
  );

  pb_mcast_unroller #(.MeshDimX(3), .MeshDimY(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .in_addr_i(in_addr), .in_mask_i(in_mask), .in_sel_x_i(in_sel_x), .in_sel_y_i(in_sel_y),
    .in_user_i(in_user), .out_valid_o(b_out_valid), .out_ready_i(out_ready),
    .out_addr_o(b_addr), .out_x_o(b_x), .out_y_o(b_y), .out_user_o(b_user),
    .out_last_o(b_last), .busy_o(b_busy), .err_o(b_err)
`ifdef PB_MCAST_UNROLL_STATS_EN
    , .stat_beats_o(b_sb), .stat_skipped_o(b_ss), .stat_err_o(b_se)
`endif
  );

  // Beat collectors: a beat is recorded when it will be accepted at the next edge.
  always @(negedge clk) begin
    beat_t b;
    if (!rst && a_out_valid && out_ready) begin
      b.addr = a_addr; b.x = a_x; b.y = a_y; b.last = a_last; b.user = a_user;
      qa.push_back(b);
      ca.push_back(cyc);
    end
    if (!rst && b_out_valid && out_ready) begin
      b.addr = b_addr; b.x = b_x; b.y = b_y; b.last = b_last; b.user = b_user;
      qb.push_back(b);
    end
    if (!rst && a_err) a_err_cnt++;
  end

  task automatic send(input logic [47:0] addr, input logic [47:0] mask,
                      input logic [11:0] sx, input logic [11:0] sy, input logic [7:0] user);
    in_valid = 1'b1; in_addr = addr; in_mask = mask;
    in_sel_x = sx; in_sel_y = sy; in_user = user;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((a_busy || b_busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (a_busy || b_busy) begin
      errors++;
      $display("FAIL wait_idle: busy a=%b b=%b after %0d cycles, want idle", a_busy, b_busy, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_mask = '0;
    in_sel_x = '0; in_sel_y = '0; in_user = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", a_err); end
    checks++; if (a_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", a_last); end
    checks++; if (a_addr !== 48'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", a_addr); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_b_in_ready: got %b want 1", b_in_ready); end
  endtask

  // m=0, x=1 y=2: single beat, valid exactly two edges after the handshake.
  task automatic test_single();
    int ba = qa.size(); int bb = qb.size(); int ea = a_err_cnt;
    out_ready = 1'b1;
    send(48'h2105, 48'h0, {6'd8, 6'd4}, {6'd12, 6'd4}, 8'h3C);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", a_out_valid); end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", a_busy); end
    @(posedge clk); #1;
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_t2: got %b want 1", a_out_valid); end
    checks++; if (a_last !== 1'b1) begin errors++; $display("FAIL single_last: got %b want 1", a_last); end
    checks++; if (a_x !== 6'd1 || a_y !== 6'd2) begin errors++; $display("FAIL single_xy: got %0d,%0d want 1,2", a_x, a_y); end
    checks++; if (a_addr !== 48'h2105) begin errors++; $display("FAIL single_addr: got %h want 2105", a_addr); end
    checks++; if (a_user !== 8'h3C) begin errors++; $display("FAIL single_user: got %h want 3c", a_user); end
    wait_idle(20);
    checks++; if (qa.size() - ba != 1) begin errors++; $display("FAIL single_count_a: got %0d want 1", qa.size() - ba); end
    checks++; if (qb.size() - bb != 1) begin errors++; $display("FAIL single_count_b: got %0d want 1", qb.size() - bb); end
    checks++; if (a_err_cnt != ea) begin errors++; $display("FAIL single_err: got %0d pulses want 0", a_err_cnt - ea); end
  endtask

  // X field mask 0b11: A emits x=0..3 back-to-back, B (MeshDimX=3) drops x=3.
  task automatic test_back_to_back();
    int ba = qa.size(); int bb = qb.size();
    out_ready = 1'b1;
    send(48'h00A0, 48'h300, {6'd8, 6'd2}, {6'd12, 6'd2}, 8'h11);
    wait_idle(40);
    checks++; if (qa.size() - ba != 4) begin errors++; $display("FAIL row_count_a: got %0d want 4", qa.size() - ba); end
    for (int i = 0; i < 4 && ba + i < qa.size(); i++) begin
      logic [47:0] ea;
      ea = 48'hA0 | (48'(i) << 8);
      checks++;
      if (qa[ba+i].addr !== ea || qa[ba+i].x !== 6'(i) || qa[ba+i].y !== 6'd0 ||
          qa[ba+i].last !== (i == 3) || qa[ba+i].user !== 8'h11) begin
        errors++;
        $display("FAIL row_beat_a%0d: got addr=%h x=%0d y=%0d last=%b want addr=%h x=%0d y=0 last=%b",
                 i, qa[ba+i].addr, qa[ba+i].x, qa[ba+i].y, qa[ba+i].last, ea, i, (i == 3));
      end
      if (i > 0) begin
        checks++;
        if (ca[ba+i] != ca[ba+i-1] + 1) begin
          errors++;
          $display("FAIL row_gap_a%0d: got beat gap %0d cycles want 1", i, ca[ba+i] - ca[ba+i-1]);
        end
      end
    end
    checks++; if (qb.size() - bb != 3) begin errors++; $display("FAIL row_count_b: got %0d want 3", qb.size() - bb); end
    for (int i = 0; i < 3 && bb + i < qb.size(); i++) begin
      checks++;
      if (qb[bb+i].x !== 6'(i) || qb[bb+i].last !== (i == 2)) begin
        errors++;
        $display("FAIL row_beat_b%0d: got x=%0d last=%b want x=%0d last=%b",
                 i, qb[bb+i].x, qb[bb+i].last, i, (i == 2));
      end
    end
`ifdef PB_MCAST_UNROLL_STATS_EN
    checks++; if (b_ss !== 32'd1) begin errors++; $display("FAIL stat_skipped_b: got %0d want 1", b_ss); end
    checks++; if (a_sb !== 32'd5) begin errors++; $display("FAIL stat_beats_a: got %0d want 5", a_sb); end
`endif
  endtask

  // Base x=5 outside the mesh with m=0: no beats, one-cycle err pulse.
  task automatic test_err();
    int ba = qa.size();
    out_ready = 1'b1;
    send(48'h0500, 48'h0, {6'd8, 6'd4}, {6'd12, 6'd4}, 8'h00);
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL err_early: got %b want 0", a_err); end
    @(posedge clk); #1;
    checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b want 1", a_err); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL err_in_ready: got %b want 1", a_in_ready); end
    @(posedge clk); #1;
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL err_width: got %b want 0", a_err); end
    checks++; if (qa.size() != ba) begin errors++; $display("FAIL err_beats: got %0d want 0", qa.size() - ba); end
  endtask

  // 2x2 mask under random backpressure: order and stability while stalled.
  task automatic test_backpressure();
    int          ba = qa.size();
    int          n = 0;
    logic        stalled = 1'b0;
    logic [47:0] h_addr = '0;
    logic        h_last = 1'b0;
    logic [5:0]  ex [4] = '{6'd0, 6'd1, 6'd0, 6'd1};
    logic [5:0]  ey [4] = '{6'd0, 6'd0, 6'd1, 6'd1};
    out_ready = 1'b0;
    send(48'h0, 48'h1100, {6'd8, 6'd2}, {6'd12, 6'd2}, 8'h5A);
    while ((qa.size() - ba < 4 || a_busy) && n < 300) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (a_out_valid !== 1'b1 || a_addr !== h_addr || a_last !== h_last) begin
          errors++;
          $display("FAIL bp_stable: got v=%b addr=%h last=%b want v=1 addr=%h last=%b",
                   a_out_valid, a_addr, a_last, h_addr, h_last);
        end
      end
      stalled = a_out_valid && !out_ready;
      h_addr  = a_addr;
      h_last  = a_last;
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    checks++; if (qa.size() - ba != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", qa.size() - ba); end
    for (int i = 0; i < 4 && ba + i < qa.size(); i++) begin
      logic [47:0] ea;
      ea = (48'(ex[i]) << 8) | (48'(ey[i]) << 12);
      checks++;
      if (qa[ba+i].x !== ex[i] || qa[ba+i].y !== ey[i] || qa[ba+i].addr !== ea ||
          qa[ba+i].last !== (i == 3)) begin
        errors++;
        $display("FAIL bp_beat%0d: got x=%0d y=%0d addr=%h last=%b want x=%0d y=%0d addr=%h last=%b",
                 i, qa[ba+i].x, qa[ba+i].y, qa[ba+i].addr, qa[ba+i].last, ex[i], ey[i], ea, (i == 3));
      end
    end
    wait_idle(20);
  endtask

  // Reset while a beat is stalled in EMIT, then a clean new request.
  task automatic test_reset_mid();
    int n = 0;
    int ba;
    out_ready = 1'b0;
    send(48'h0, 48'h300, {6'd8, 6'd2}, {6'd12, 6'd2}, 8'h22);
    while (!a_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_reach_emit: got %b want 1", a_out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", a_out_valid); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", a_busy); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b want 1", a_in_ready); end
    checks++; if (a_last !== 1'b0) begin errors++; $display("FAIL rstmid_last: got %b want 0", a_last); end
    ba = qa.size();
    out_ready = 1'b1;
    send(48'h1200, 48'h0, {6'd8, 6'd4}, {6'd12, 6'd4}, 8'h77);
    wait_idle(20);
    checks++; if (qa.size() - ba != 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", qa.size() - ba); end
    if (qa.size() > ba) begin
      checks++;
      if (qa[ba].x !== 6'd2 || qa[ba].y !== 6'd1 || qa[ba].last !== 1'b1 || qa[ba].addr !== 48'h1200) begin
        errors++;
        $display("FAIL rstmid_beat: got x=%0d y=%0d last=%b addr=%h want x=2 y=1 last=1 addr=1200",
                 qa[ba].x, qa[ba].y, qa[ba].last, qa[ba].addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_err();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
